color_sram_sequencer: RTL

- Downstream stage of the color-RAM bank/lane interface: turns its asynchronous color-RAM chip strobes (_ce_color/_we_color, bank, lane select) into clean, clock-timed SRAM cycles.
- Strobes are synchronised to the fast board clock. Address, bank, lane and write data are captured once per access. The block then drives _ce_mem/_we_mem/_lb/_ub with programmable setup, strobe and hold widths, and latches read data for the color bus.

---
 rtl/color_pkg.sv | 16 +
 rtl/color_sync.sv | 23 ++
 rtl/color_sram_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/color_pkg.sv
// Shared types and widths for the color-RAM to SRAM sequencer.
package color_pkg;

  localparam int COLOR_ADDR_W = 10;
  localparam int BANK_W       = 6;
  localparam int NIBBLE_W     = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/color_sync.sv
// Multi-flop synchroniser for an active-low asynchronous strobe; resets to the inactive level.
module color_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clock) begin
    if (reset) begin
      stages <= '1;
    end else begin
      stages <= {stages[STAGES-2:0], async_in};
    end
  end

  assign sync_out = stages[STAGES-1];

endmodule

// File: rtl/color_sram_sequencer.sv
// Turns asynchronous color-RAM strobes into one clock-timed SRAM cycle per access,
// with programmable setup, strobe and hold widths and a latched read result.
module color_sram_sequencer
  import color_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      _ce_color,
  input  logic                      _we_color,
  input  logic [COLOR_ADDR_W-1:0]   address_color,
  input  logic [BANK_W-1:0]         bank_in,
  input  logic                      lane_hi,
  input  logic [NIBBLE_W-1:0]       wdata_in,
  output logic [15:0]               mem_addr,
  output logic [NIBBLE_W-1:0]       mem_wdata,
  output logic                      mem_wdata_oe,
  input  logic [NIBBLE_W-1:0]       mem_rdata,
  output logic                      _ce_mem,
  output logic                      _we_mem,
  output logic                      _lb,
  output logic                      _ub,
  output logic [NIBBLE_W-1:0]       rdata_out,
  output logic                      rdata_valid,
  output logic                      busy
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              ce_s;
  logic              we_s;
  logic              ce_prev;
  logic              lane_q;
  logic              write_q;
  logic              access_start;
  logic              active;
  logic              read_sample;

  color_sync #(.STAGES(SYNC_STAGES)) u_sync_ce (
    .clock    (clock),
    .reset    (reset),
    .async_in (_ce_color),
    .sync_out (ce_s)
  );

  color_sync #(.STAGES(SYNC_STAGES)) u_sync_we (
    .clock    (clock),
    .reset    (reset),
    .async_in (_we_color),
    .sync_out (we_s)
  );

  // Only a falling edge seen while idle starts an access, so one color access gives one SRAM cycle.
  assign access_start = (state == IDLE) && ce_prev && !ce_s;
  assign read_sample  = (state == STROBE) && (cnt == STROBE_LAST) && !write_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ce_prev <= 1'b1;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      ce_prev <= ce_s;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (access_start) state_next = SETUP;
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_next = STROBE;
          cnt_next   = '0;
        end
      end
      STROBE: begin
        if (cnt == STROBE_LAST) begin
          state_next = (HOLD_CYCLES > 0) ? HOLD : DONE;
          cnt_next   = '0;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_next = DONE;
          cnt_next   = '0;
        end
      end
      DONE: begin
        cnt_next = '0;
        if (ce_s) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    active       = (state == SETUP) || (state == STROBE) || (state == HOLD);
    busy         = active;
    _lb          = !(active && !lane_q);
    _ub          = !(active && lane_q);
    mem_wdata_oe = active && write_q;
    _ce_mem      = !(state == STROBE);
    _we_mem      = !((state == STROBE) && write_q);
  end

  // Access parameters are frozen at the start edge; later changes on the color side are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      lane_q      <= 1'b0;
      write_q     <= 1'b0;
      rdata_out   <= '0;
      rdata_valid <= 1'b0;
    end else begin
      if (access_start) begin
        mem_addr  <= {bank_in, address_color};
        mem_wdata <= wdata_in;
        lane_q    <= lane_hi;
        write_q   <= !we_s;
        if (we_s) rdata_valid <= 1'b0;
      end
      if (read_sample) begin
        rdata_out   <= mem_rdata;
        rdata_valid <= 1'b1;
      end
    end
  end

endmodule
